// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq
// Multi-cycle unsigned multiply / divide sequencer. It borrows the shared ALU
// for one ADD (multiply) or SUB (divide) per iteration. The shifts, the low
// half and the operand are kept in local registers.
//   Multiply: dw x dw -> {res_hi, res_lo}, shift-and-add.
//   Divide:   dw / dw -> res_lo = quotient, res_hi = remainder, restoring.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_start, i_op_div   request (IDLE only) and operation select (1 = divide)
//   i_a, i_b            multiplicand/dividend, multiplier/divisor
//   i_hold              external stall; freezes the sequencer
//   o_busy, o_done      busy from acceptance through DONE; one-cycle done
//   o_div_zero          divide-by-zero flag, valid with done
//   o_res_hi, o_res_lo  product high/low or remainder/quotient
//   o_alu_*             drive into the shared ALU (o_alu_own selects it)
//   i_alu_out, i_alu_co registered ALU result and carry
module alu_muldiv_seq #(
  parameter int dw = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_op_div,
  input  logic [dw-1:0] i_a,
  input  logic [dw-1:0] i_b,
  input  logic          i_hold,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_div_zero,
  output logic [dw-1:0] o_res_hi,
  output logic [dw-1:0] o_res_lo,
  output logic          o_alu_own,
  output logic [3:0]    o_alu_op,
  output logic [dw-1:0] o_alu_ai,
  output logic [dw-1:0] o_alu_bi,
  output logic          o_alu_ci,
  output logic          o_alu_right,
  output logic          o_alu_rotate,
  output logic [3:0]    o_alu_ei,
  output logic          o_alu_rdy,
  input  logic [dw-1:0] i_alu_out,
  input  logic          i_alu_co
);

  localparam int CW = (dw > 1) ? $clog2(dw) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_op_div;
  logic [dw-1:0] r_hi;
  logic [dw-1:0] r_lo;
  logic [dw-1:0] r_opnd;     // multiplier m or divisor d
  logic [CW-1:0] r_cnt;
  logic          r_div_zero;
  logic [dw-1:0] r_res_hi;
  logic [dw-1:0] r_res_lo;

  logic          w_accept;
  logic          w_b_zero;
  logic          w_last;
  logic [dw:0]   w_r17;      // partial remainder shifted left by one bit
  logic          w_ok;
  logic [dw-1:0] w_hi_next;
  logic [dw-1:0] w_lo_next;

  assign w_accept = (r_state == S_IDLE) && i_start && !i_hold;
  assign w_b_zero = (i_b == '0);
  assign w_last   = (r_cnt == CW'(dw - 1));
  assign w_r17    = {r_hi, r_lo[dw-1]};
  // The trial subtraction succeeds if the ALU saw no borrow, or if the bit
  // shifted out of the top makes the partial remainder exceed any divisor.
  assign w_ok     = i_alu_co | w_r17[dw];

  always_comb begin
    w_hi_next = {i_alu_co, i_alu_out[dw-1:1]};
    w_lo_next = {i_alu_out[0], r_lo[dw-1:1]};
    if (r_op_div) begin
      w_hi_next = w_ok ? i_alu_out : w_r17[dw-1:0];
      w_lo_next = {r_lo[dw-2:0], w_ok};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_alu_op     = 4'b0011;
    o_alu_ai     = '0;
    o_alu_bi     = '0;
    o_alu_ci     = 1'b0;
    o_alu_rdy    = 1'b0;
    if (r_state == S_ISSUE) begin
      o_alu_rdy = !i_hold;
      if (r_op_div) begin
        o_alu_op = 4'b0111;
        o_alu_ai = w_r17[dw-1:0];
        o_alu_bi = r_opnd;
        o_alu_ci = 1'b1;
      end else begin
        o_alu_ai = r_hi;
        o_alu_bi = r_lo[0] ? r_opnd : '0;
      end
    end
    if (!i_hold) begin
      case (r_state)
        S_IDLE:    if (i_start) w_state_next = (i_op_div && w_b_zero) ? S_DONE : S_ISSUE;
        S_ISSUE:   w_state_next = S_CAPTURE;
        S_CAPTURE: w_state_next = w_last ? S_DONE : S_ISSUE;
        S_DONE:    w_state_next = S_IDLE;
        default:   w_state_next = S_IDLE;
      endcase
    end
  end

  // Results are published on entry to DONE so they are already valid while
  // done is high; DONE itself has nothing left to update.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op_div   <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_opnd     <= '0;
      r_cnt      <= '0;
      r_div_zero <= 1'b0;
      r_res_hi   <= '0;
      r_res_lo   <= '0;
    end else if (!i_hold) begin
      if (w_accept) begin
        r_op_div   <= i_op_div;
        r_hi       <= '0;
        r_lo       <= i_a;
        r_opnd     <= i_b;
        r_cnt      <= '0;
        r_div_zero <= i_op_div && w_b_zero;
        if (i_op_div && w_b_zero) begin
          r_res_hi <= i_a;
          r_res_lo <= '1;
        end
      end else if (r_state == S_CAPTURE) begin
        r_hi <= w_hi_next;
        r_lo <= w_lo_next;
        if (w_last) begin
          r_res_hi <= w_hi_next;
          r_res_lo <= w_lo_next;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE) && !i_hold;
  assign o_div_zero   = r_div_zero;
  assign o_res_hi     = r_res_hi;
  assign o_res_lo     = r_res_lo;
  assign o_alu_own    = o_busy;
  assign o_alu_right  = 1'b0;
  assign o_alu_rotate = 1'b0;
  assign o_alu_ei     = 4'b0000;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
module tb_alu_muldiv_seq;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_start = 1'b0;
  logic          i_op_div = 1'b0;
  logic [DW-1:0] i_a = '0;
  logic [DW-1:0] i_b = '0;
  logic          i_hold = 1'b0;
  logic          o_busy, o_done, o_div_zero, o_alu_own, o_alu_ci;
  logic          o_alu_right, o_alu_rotate, o_alu_rdy;
  logic [DW-1:0] o_res_hi, o_res_lo, o_alu_ai, o_alu_bi;
  logic [3:0]    o_alu_op, o_alu_ei;
  logic [DW-1:0] alu_out = '0;
  logic          alu_co = 1'b0;

  int chk_cnt = 0;
  int pass_cnt = 0;
  bit cmp_en = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.dw(DW)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_op_div(i_op_div),
    .i_a(i_a), .i_b(i_b), .i_hold(i_hold),
    .o_busy(o_busy), .o_done(o_done), .o_div_zero(o_div_zero),
    .o_res_hi(o_res_hi), .o_res_lo(o_res_lo), .o_alu_own(o_alu_own),
    .o_alu_op(o_alu_op), .o_alu_ai(o_alu_ai), .o_alu_bi(o_alu_bi),
    .o_alu_ci(o_alu_ci), .o_alu_right(o_alu_right), .o_alu_rotate(o_alu_rotate),
    .o_alu_ei(o_alu_ei), .o_alu_rdy(o_alu_rdy),
    .i_alu_out(alu_out), .i_alu_co(alu_co)
  );

  // Shared ALU stand-in: add (0011) or subtract-with-carry (0111), result
  // registered only when RDY is high.
  logic [DW:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, o_alu_ai} + {1'b0, o_alu_bi} + (DW+1)'(o_alu_ci);
    if (o_alu_op == 4'b0111)
      alu_sum = {1'b0, o_alu_ai} + {1'b0, ~o_alu_bi} + (DW+1)'(o_alu_ci);
  end
  always @(posedge clk) begin
    if (o_alu_rdy) begin
      alu_out <= alu_sum[DW-1:0];
      alu_co  <= alu_sum[DW];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Behavioural model: each accepted operation takes a fixed number of
  // non-held cycles; the answer comes from plain arithmetic.
  bit            m_busy = 0;
  int            m_cnt = 0;
  int            m_total = 0;
  bit            m_dz = 0;
  logic [DW-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  always @(posedge clk) begin
    if (i_reset) begin
      m_busy <= 0; m_cnt <= 0; m_total <= 0; m_dz <= 0; m_hi <= '0; m_lo <= '0;
    end else if (!i_hold) begin
      if (!m_busy) begin
        if (i_start) begin
          m_busy <= 1;
          m_cnt  <= 1;
          m_dz   <= 0;
          if (i_op_div && i_b == 0) begin
            m_total <= 1; m_dz <= 1; m_hi <= i_a; m_lo <= '1;
          end else begin
            m_total <= 2 * DW + 1;
            if (i_op_div) begin
              p_hi <= i_a % i_b; p_lo <= i_a / i_b;
            end else begin
              {p_hi, p_lo} <= 32'(i_a) * 32'(i_b);
            end
          end
        end
      end else if (m_cnt == m_total) begin
        m_busy <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
        if (m_cnt + 1 == m_total) begin
          m_hi <= p_hi; m_lo <= p_lo;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 32'(o_busy), 32'(m_busy));
      check("alu_own", 32'(o_alu_own), 32'(m_busy));
      check("done", 32'(o_done), 32'(m_busy && m_cnt == m_total && !i_hold));
      check("div_zero", 32'(o_div_zero), 32'(m_dz));
      check("res_hi", 32'(o_res_hi), 32'(m_hi));
      check("res_lo", 32'(o_res_lo), 32'(m_lo));
      check("alu_rdy", 32'(o_alu_rdy),
            32'(m_busy && !i_hold && m_cnt < m_total && (m_cnt % 2) == 1));
      check("alu_consts", 32'({o_alu_right, o_alu_rotate, o_alu_ei}), 32'(0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait (bounded) for done; optional hold window
  // [hold_from, hold_to) and a stray start pulse at cycle restart_at.
  task automatic run_op(input string name, input logic div, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] exp_hi,
                        input logic [DW-1:0] exp_lo, input logic exp_dz, input int exp_lat,
                        input int hold_from, input int hold_to, input int restart_at);
    int lat;
    i_op_div = div; i_a = a; i_b = b; i_start = 1'b1;
    step();
    lat = 1;
    while (lat < 100) begin
      i_start = (lat == restart_at);
      if (lat == restart_at) begin
        i_a = ~a; i_b = 16'h0003; i_op_div = ~div;
      end
      i_hold = (lat >= hold_from && lat < hold_to);
      #1;
      if (o_done) break;
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " res_hi"}, 32'(o_res_hi), 32'(exp_hi));
    check({name, " res_lo"}, 32'(o_res_lo), 32'(exp_lo));
    check({name, " div_zero"}, 32'(o_div_zero), 32'(exp_dz));
    $display("%s: a=%h b=%h div=%0d -> hi=%h lo=%h dz=%0d lat=%0d",
             name, a, b, div, o_res_hi, o_res_lo, o_div_zero, lat);
    i_start = 1'b0; i_hold = 1'b0;
    step();
    step();
  endtask

  initial begin
    step();
    cmp_en = 1;
    step();
    i_reset = 1'b0;
    check("reset busy", 32'(o_busy), 32'(0));
    check("reset done", 32'(o_done), 32'(0));
    check("reset res", 32'({o_res_hi, o_res_lo}), 32'(0));
    check("reset alu_rdy", 32'(o_alu_rdy), 32'(0));
    step();

    run_op("mul1", 1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0, 33, 0, 0, 0);
    run_op("mul_max", 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 33, 0, 0, 0);
    run_op("mul_zero", 1'b0, 16'h0000, 16'hABCD, 16'h0000, 16'h0000, 1'b0, 33, 0, 0, 0);
    run_op("mul_ff", 1'b0, 16'h00FF, 16'h0101, 16'h0000, 16'hFFFF, 1'b0, 33, 0, 0, 0);
    run_op("div1", 1'b1, 16'hFFFF, 16'h0010, 16'h000F, 16'h0FFF, 1'b0, 33, 0, 0, 0);
    run_op("div_r17", 1'b1, 16'hFFFF, 16'h8001, 16'h7FFE, 16'h0001, 1'b0, 33, 0, 0, 0);
    run_op("div_small", 1'b1, 16'h0005, 16'h0007, 16'h0005, 16'h0000, 1'b0, 33, 0, 0, 0);
    run_op("div_zero", 1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1, 0, 0, 0);
    run_op("mul_hold", 1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0, 38, 10, 15, 4);
    run_op("div_hold_done", 1'b1, 16'hFFFF, 16'h0010, 16'h000F, 16'h0FFF, 1'b0, 35, 33, 35, 0);

    // start while held in IDLE is ignored
    i_hold = 1'b1; i_start = 1'b1; i_op_div = 1'b0; i_a = 16'h0002; i_b = 16'h0003;
    step();
    i_hold = 1'b0; i_start = 1'b0;
    check("hold_idle busy", 32'(o_busy), 32'(0));
    $display("hold_idle: busy=%0d", o_busy);
    step();

    // reset during an operation aborts it
    i_op_div = 1'b0; i_a = 16'h1234; i_b = 16'h5678; i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (9) step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    check("abort busy", 32'(o_busy), 32'(0));
    check("abort done", 32'(o_done), 32'(0));
    check("abort res", 32'({o_res_hi, o_res_lo}), 32'(0));
    $display("abort: busy=%0d done=%0d hi=%h lo=%h", o_busy, o_done, o_res_hi, o_res_lo);
    step();
    run_op("mul_after_rst", 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 33, 0, 0, 0);

    cmp_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
